// File: rtl/calc_operand_sequencer.sv
// Calculator operand sequencer: synchronises and debounces ENTER, captures
// operand A, operand B and the opcode in turn, then presents them to the ALU.
module calc_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic [1:0] op_in,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] opa,
  output logic [3:0] opb,
  output logic [1:0] op_ctrl,
  output logic       result_valid,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             enter_sync_p0;
  logic             enter_sync_p1;
  logic             clear_sync_p0;
  logic             clear_sync_p1;
  logic [CNT_W-1:0] db_cnt_p2;
  logic             db_level_p2;
  logic             db_level_p3;
  logic             enter_pulse;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       opa_d;
  logic [3:0]       opb_d;
  logic [1:0]       op_ctrl_d;
  logic             valid_d;

  // Stages 0/1: two-flop synchronisers for both asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_sync_p0 <= 1'b0;
      enter_sync_p1 <= 1'b0;
      clear_sync_p0 <= 1'b0;
      clear_sync_p1 <= 1'b0;
    end else begin
      enter_sync_p0 <= btn_enter;
      enter_sync_p1 <= enter_sync_p0;
      clear_sync_p0 <= btn_clear;
      clear_sync_p1 <= clear_sync_p0;
    end
  end

  // Stage 2: ENTER debounce; the level flips only after an unbroken run of
  // DEBOUNCE_CYCLES synced samples that disagree with it
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_p2   <= '0;
      db_level_p2 <= 1'b0;
      db_level_p3 <= 1'b0;
    end else begin
      db_level_p3 <= db_level_p2;
      if (enter_sync_p1 == db_level_p2) begin
        db_cnt_p2 <= '0;
      end else if (db_cnt_p2 == CNT_LAST) begin
        db_level_p2 <= ~db_level_p2;
        db_cnt_p2   <= '0;
      end else begin
        db_cnt_p2 <= db_cnt_p2 + CNT_W'(1);
      end
    end
  end

  assign enter_pulse = db_level_p2 & ~db_level_p3;

  // Stage 3: entry FSM; a synced clear overrides any pulse in the same cycle
  always_comb begin
    state_d   = state_q;
    opa_d     = opa;
    opb_d     = opb;
    op_ctrl_d = op_ctrl;
    valid_d   = result_valid;
    if (clear_sync_p1) begin
      state_d   = LOAD_A;
      opa_d     = 4'd0;
      opb_d     = 4'd0;
      op_ctrl_d = 2'd0;
      valid_d   = 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        LOAD_A: begin
          opa_d   = sw_in;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          opb_d   = sw_in;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_ctrl_d = op_in;
          valid_d   = 1'b1;
          state_d   = SHOW;
        end
        SHOW: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_A;
      opa          <= 4'd0;
      opb          <= 4'd0;
      op_ctrl      <= 2'd0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa          <= opa_d;
      opb          <= opb_d;
      op_ctrl      <= op_ctrl_d;
      result_valid <= valid_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_calc_operand_sequencer;

  localparam int DC = 4;
  localparam int CW = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [3:0] sw_in     = 4'd0;
  logic [1:0] op_in     = 2'd0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [1:0] op_ctrl;
  logic       result_valid;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit         e_line[$];
  bit         c_line[$];
  bit         run[$];
  bit         m_lvl;
  bit         m_lvl_d;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_op;
  bit         m_v;
  int         m_ph;

  calc_operand_sequencer #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_in       (sw_in),
    .op_in       (op_in),
    .btn_enter   (btn_enter),
    .btn_clear   (btn_clear),
    .opa         (opa),
    .opb         (opb),
    .op_ctrl     (op_ctrl),
    .result_valid(result_valid),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge of the reference: buttons reach the logic two edges late,
  // a level change needs DC consecutive disagreeing samples, and each accepted
  // rising level advances the entry one step (clear wins).
  task automatic model_edge();
    bit es;
    bit cs;
    bit pulse;
    if (rst) begin
      e_line.delete(); e_line.push_back(1'b0); e_line.push_back(1'b0);
      c_line.delete(); c_line.push_back(1'b0); c_line.push_back(1'b0);
      run.delete();
      m_lvl = 1'b0; m_lvl_d = 1'b0;
      m_a = 4'd0; m_b = 4'd0; m_op = 2'd0; m_v = 1'b0; m_ph = 0;
      return;
    end
    es = e_line.pop_front(); e_line.push_back(btn_enter);
    cs = c_line.pop_front(); c_line.push_back(btn_clear);
    pulse = m_lvl && !m_lvl_d;
    m_lvl_d = m_lvl;
    if (es == m_lvl) run.delete();
    else run.push_back(es);
    if (run.size() == DC) begin
      m_lvl = !m_lvl;
      run.delete();
    end
    if (cs) begin
      m_a = 4'd0; m_b = 4'd0; m_op = 2'd0; m_v = 1'b0; m_ph = 0;
    end else if (pulse) begin
      case (m_ph)
        0: m_a = sw_in;
        1: m_b = sw_in;
        2: begin m_op = op_in; m_v = 1'b1; end
        default: m_v = 1'b0;
      endcase
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    btn_enter = 1'b1;
    repeat (hi) tick();
    btn_enter = 1'b0;
    repeat (lo) tick();
  endtask

  function automatic logic [12:0] dut_vec();
    return {opa, opb, op_ctrl, result_valid, phase};
  endfunction

  function automatic logic [12:0] mdl_vec();
    return {m_a, m_b, m_op, m_v, 2'(m_ph)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (dut_vec() !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), 13'd0);
    end
    rst = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (dut_vec() !== 13'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", dut_vec(), 13'd0);
    end
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL idle_model: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_full_entry();
    logic [12:0] exp;
    sw_in = 4'b0101; press(10, 10);
    sw_in = 4'b0011; press(10, 10);
    op_in = 2'b01;   press(10, 10);
    exp = {4'd5, 4'd3, 2'b01, 1'b1, 2'b11};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL full_entry: got %h expected %h", dut_vec(), exp);
    end
    press(10, 10);
    exp = {4'd5, 4'd3, 2'b01, 1'b0, 2'b00};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL fourth_press: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_bounce();
    logic [12:0] exp;
    repeat (5) begin
      btn_enter = 1'b1; tick(); tick();
      btn_enter = 1'b0; tick(); tick();
    end
    repeat (10) tick();
    exp = {4'd5, 4'd3, 2'b01, 1'b0, 2'b00};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL bounce_reject: got %h expected %h", dut_vec(), exp);
    end
    press(4, 12);
    exp = {4'd3, 4'd3, 2'b01, 1'b0, 2'b01};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL min_press: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_hold();
    logic [12:0] exp;
    btn_clear = 1'b1; repeat (4) tick();
    btn_clear = 1'b0; repeat (4) tick();
    n_checks++;
    if (dut_vec() !== 13'd0) begin
      n_fail++;
      $display("FAIL clear_idle: got %h expected %h", dut_vec(), 13'd0);
    end
    sw_in = 4'hA;
    btn_enter = 1'b1;
    repeat (200) tick();
    exp = {4'hA, 4'd0, 2'b00, 1'b0, 2'b01};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL hold_single: got %h expected %h", dut_vec(), exp);
    end
    btn_enter = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL hold_release: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_clear_mid();
    logic [12:0] exp;
    btn_clear = 1'b1; repeat (4) tick();
    btn_clear = 1'b0; repeat (4) tick();
    sw_in = 4'd9; press(10, 10);
    sw_in = 4'd2; press(10, 10);
    exp = {4'd9, 4'd2, 2'b00, 1'b0, 2'b10};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL load_op_setup: got %h expected %h", dut_vec(), exp);
    end
    btn_clear = 1'b1;
    btn_enter = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (dut_vec() !== 13'd0) begin
      n_fail++;
      $display("FAIL clear_mid: got %h expected %h", dut_vec(), 13'd0);
    end
    repeat (12) tick();
    btn_clear = 1'b0;
    btn_enter = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (dut_vec() !== 13'd0) begin
      n_fail++;
      $display("FAIL clear_no_advance: got %h expected %h", dut_vec(), 13'd0);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [12:0] exp;
    sw_in = 4'd7;
    btn_enter = 1'b1;
    repeat (4) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (phase !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_db_early: got phase %b expected %b", phase, 2'b00);
    end
    tick();
    exp = {4'd7, 4'd0, 2'b00, 1'b0, 2'b01};
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL rst_db_pulse: got %h expected %h", dut_vec(), exp);
    end
    btn_enter = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL rst_db_model: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int len = int'($urandom_range(1, 12));
      btn_enter = 1'($urandom_range(0, 1));
      btn_clear = ($urandom_range(0, 15) == 0);
      sw_in     = 4'($urandom);
      op_in     = 2'($urandom);
      for (int k = 0; k < len; k++) begin
        tick();
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++;
          $display("FAIL random_seq step %0d: got %h expected %h", i, dut_vec(), mdl_vec());
        end
      end
    end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL random_tail: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_bounce();
    test_hold();
    test_clear_mid();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_operand_sequencer.md
Name: calc_operand_sequencer

Overview:
- Upstream front-end of the calculator datapath; feeds the 4-bit ALU operand inputs and its 2-bit operation select.
- Operator sets the slide switches and presses ENTER three times: first for operand A, second for operand B, third for the opcode.
- Block then holds all three stable and flags them valid for the ALU/seven-segment path.
- Contains button synchronisation, debounce and a 4-state entry FSM.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synced cycles required before the debounced button level changes (5 ms at 50 MHz). Must be at least 2.
- CNT_W, 18: debounce counter width. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_in  in  4  operand value switches (asynchronous, quasi-static)
- op_in  in  2  opcode switches: 00 sub, 01 add, 10 or, 11 two's complement of A
- btn_enter  in  1  raw ENTER push-button, active high, bouncy, asynchronous
- btn_clear  in  1  raw CLEAR push-button, active high, asynchronous
- opa  out  4  registered operand A, to ALU i1
- opb  out  4  registered operand B, to ALU i2
- op_ctrl  out  2  registered opcode, to ALU ctrl
- result_valid  out  1  high while opa/opb/op_ctrl form a complete entry
- phase  out  2  current FSM state, for status LEDs

Behaviour:
- Reset (rst high at a clk edge): opa=0, opb=0, op_ctrl=00, result_valid=0, phase=00 (LOAD_A).
- Reset also clears all synchroniser flops, the debounce counter and the debounced level to 0.
- Reset has priority over everything, including mid-sequence.
- Synchronisers: btn_enter and btn_clear each pass through a 2-flop synchroniser. sw_in and op_in are sampled directly; they are assumed static at press time.
- ENTER debounce:
  - If the synced level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - A level change is therefore accepted after exactly DEBOUNCE_CYCLES consecutive differing synced samples.
- enter_pulse is the debounced rising edge: debounced level high and its 1-cycle-delayed copy low. It is exactly one cycle wide per press.
- A held button never repeats. Release is also debounced and is required before the next pulse.
- Clear: the synced btn_clear is level-sensitive and not debounced. While it is high:
  - opa, opb, op_ctrl go to 0, result_valid goes to 0, phase goes to LOAD_A.
  - enter_pulse is ignored.
  - Clear beats ENTER in the same cycle.
- FSM, with phase encoding LOAD_A=00, LOAD_B=01, LOAD_OP=10, SHOW=11:
  - LOAD_A + enter_pulse: opa<=sw_in, go to LOAD_B.
  - LOAD_B + enter_pulse: opb<=sw_in, go to LOAD_OP.
  - LOAD_OP + enter_pulse: op_ctrl<=op_in, result_valid<=1, go to SHOW.
  - SHOW + enter_pulse: result_valid<=0, go to LOAD_A. opa/opb/op_ctrl hold until overwritten.
  - With no enter_pulse, all state and outputs hold.
- Opcode 11 still requires the full three-press sequence. opb is captured but unused downstream.
- Latency:
  - Press stable from cycle t: synced high at t+2, debounced toggles at the edge ending cycle t+1+DEBOUNCE_CYCLES, enter_pulse is high the following cycle.
  - Captured register and phase update at the edge where enter_pulse is high.
  - result_valid rises at the same edge as the op_ctrl capture.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
- Reset then idle: rst 3 cycles -> opa=0, opb=0, op_ctrl=00, result_valid=0, phase=00. Held with buttons low for 20 cycles, nothing changes.
- Full entry: sw=0101 press, sw=0011 press, op=01 press (each press 10 cycles, releases 10 cycles) -> opa=5, opb=3, op_ctrl=01, result_valid=1, phase=11. The fourth press returns phase=00 and result_valid=0 with opa=5 retained.
- Bounce rejection: ENTER toggles high/low every 2 cycles for 20 cycles, then stays low -> no enter_pulse, phase unchanged. Then held high for exactly 4 synced cycles -> exactly one pulse.
- Hold: ENTER held for 200 cycles in LOAD_A -> a single advance to LOAD_B only.
- Clear mid-sequence: in LOAD_OP with opa=9, opb=2, assert clear (and ENTER in the same cycle) -> 2 cycles later all outputs 0, phase=00, no advance.
- Reset mid-debounce: rst asserted while the counter is at 2 with ENTER high -> after rst deasserts, a pulse occurs only after 2+4 further stable cycles.
